// File: rtl/fetch_instr_queue_if.sv
// Fetch -> decode instruction queue bus.
// master: the fetch/decode side that drives beats and consumes the head.
// slave:  the queue itself.
interface fetch_instr_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          iFlush;
  logic          iFetchValid;
  logic [31:0]   iFetchPC;
  logic [31:0]   iFetchInstr;
  logic          oFetchReady;
  logic          oDecValid;
  logic [31:0]   oDecPC;
  logic [31:0]   oDecInstr;
  logic          iDecReady;
  logic [CW-1:0] oCount;
  logic          oEmpty;
  logic          oFull;

  modport master (
    output iFlush, iFetchValid, iFetchPC, iFetchInstr, iDecReady,
    input  oFetchReady, oDecValid, oDecPC, oDecInstr, oCount, oEmpty, oFull
  );

  modport slave (
    input  iFlush, iFetchValid, iFetchPC, iFetchInstr, iDecReady,
    output oFetchReady, oDecValid, oDecPC, oDecInstr, oCount, oEmpty, oFull
  );
endinterface

// File: rtl/fetch_instr_queue.sv
// Circular FIFO of {PC, instruction} pairs between fetch and decode.
// oFetchReady depends only on registered occupancy, so decode stalls never reach fetch
// combinationally. A flush drops every entry plus the same-cycle fetch beat.
// Optional macro FETCH_Q_BYPASS_EN: when empty, a fetch beat is shown to decode in the
// same cycle and is not written if decode takes it.
module fetch_instr_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic             iClk,
  input logic             iRst,
  fetch_instr_queue_if.slave q
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic empty, full, bypass, dec_valid, push, pop;

  // Occupancy flags and handshake qualification.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FullCnt);
`ifdef FETCH_Q_BYPASS_EN
    bypass = empty & q.iFetchValid & ~q.iFlush;
`else
    bypass = 1'b0;
`endif
    dec_valid = (~empty | bypass) & ~q.iFlush;
    // pop only ever retires a stored entry; a bypassed beat never touches storage
    pop  = ~empty & dec_valid & q.iDecReady;
    push = q.iFetchValid & ~full & ~q.iFlush & ~(bypass & q.iDecReady);
  end

  // Decode-side and status outputs.
  always_comb begin
    q.oFetchReady = ~full;
    q.oDecValid   = dec_valid;
    q.oDecPC      = '0;
    q.oDecInstr   = NOP_INSTR;
    if (dec_valid) begin
      if (bypass) begin
        q.oDecPC    = q.iFetchPC;
        q.oDecInstr = q.iFetchInstr;
      end else begin
        q.oDecPC    = pc_mem[rd_ptr_q];
        q.oDecInstr = instr_mem[rd_ptr_q];
      end
    end
    q.oCount = count_q;
    q.oEmpty = empty;
    q.oFull  = full;
  end

  // Pointer and occupancy next state; flush overrides any handshake.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (q.iFlush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset taking priority over flush.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are not reset since occupancy guards every read.
  always_ff @(posedge iClk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= q.iFetchPC;
      instr_mem[wr_ptr_q] <= q.iFetchInstr;
    end
  end

endmodule
